conv_via_tiling_sdiv_32s_31ns_32_seq: RTL and testbench

Sequential radix-2 restoring divider: signed 32-bit dividend by unsigned 31-bit divisor, producing a 32-bit signed quotient and remainder with C truncation semantics. It is the inverse companion of the conv tiling datapath's unsigned-by-signed multiplier: it recovers per-tile scale factors and index quotients. One division takes 34 cycles behind an ap_ctrl_hs-style start/done handshake, so the HLS scheduler can share a single instance.

---
 rtl/conv_via_tiling_div_pkg.sv | 13 +
 rtl/conv_via_tiling_sdiv_32s_31ns_32_seq_if.sv | 19 +
 rtl/conv_via_tiling_div_step.sv | 19 +
 rtl/conv_via_tiling_sdiv_32s_31ns_32_seq.sv | 102 ++++++++++
 tb/tb_conv_via_tiling_sdiv_32s_31ns_32_seq.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/conv_via_tiling_div_pkg.sv
// Shared types and constants for the sequential signed-by-unsigned divider.
package conv_via_tiling_div_pkg;
  localparam int DIV_ITERS = 32;
  localparam int DIN0_W    = 32;
  localparam int DIN1_W    = 31;
  localparam int DOUT_W    = 32;
  localparam int CNT_W     = 5;

  localparam logic [DOUT_W-1:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [DOUT_W-1:0] SAT_NEG = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/conv_via_tiling_sdiv_32s_31ns_32_seq_if.sv
// Start/done handshake plus operand and result buses of the divider.
interface conv_via_tiling_sdiv_32s_31ns_32_seq_if;
  import conv_via_tiling_div_pkg::*;

  logic              ap_start;
  logic              ap_ready;
  logic              ap_idle;
  logic              ap_done;
  logic [DIN0_W-1:0] din0;
  logic [DIN1_W-1:0] din1;
  logic [DOUT_W-1:0] dout;
  logic [DOUT_W-1:0] rem;
  logic              dbz;

  modport master (output ap_start, din0, din1,
                  input  ap_ready, ap_idle, ap_done, dout, rem, dbz);
  modport slave  (input  ap_start, din0, din1,
                  output ap_ready, ap_idle, ap_done, dout, rem, dbz);
endinterface

// File: rtl/conv_via_tiling_div_step.sv
// One restoring-division step: shift {rem,mag} left, subtract divisor if it fits.
module conv_via_tiling_div_step
  import conv_via_tiling_div_pkg::*;
(
  input  logic [DOUT_W-1:0] rem_in,
  input  logic [DIN0_W-1:0] mag_in,
  input  logic [DIN1_W-1:0] divisor,
  output logic [DOUT_W-1:0] rem_out,
  output logic [DIN0_W-1:0] mag_out
);
  logic [DOUT_W:0] sh;
  logic            ge;

  // 33 bits so the shifted remainder can never wrap before the compare
  assign sh      = {rem_in, mag_in[DIN0_W-1]};
  assign ge      = sh >= {2'b00, divisor};
  assign rem_out = ge ? DOUT_W'(sh - {2'b00, divisor}) : sh[DOUT_W-1:0];
  assign mag_out = {mag_in[DIN0_W-2:0], ge};
endmodule

// File: rtl/conv_via_tiling_sdiv_32s_31ns_32_seq.sv
// Fixed 34-cycle signed/unsigned divider with C truncation and divide-by-zero saturation.
module conv_via_tiling_sdiv_32s_31ns_32_seq
  import conv_via_tiling_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 31,
  parameter int dout_WIDTH = 32
)(
  input  logic ap_clk,
  input  logic ap_rst,
  conv_via_tiling_sdiv_32s_31ns_32_seq_if.slave bus
);
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic                   neg_q, zero_q;
  logic [din0_WIDTH-1:0]  din0_q, mag_q, mag_nx, abs_din0;
  logic [dout_WIDTH-1:0]  prem_q, prem_nx;
  logic [din1_WIDTH-1:0]  dvs_q;

  // ID is an instance tag only
  if (ID < 0) begin : g_id_tag
  end

  // |-2^31| is 2^31, which fits the unsigned magnitude
  assign abs_din0 = bus.din0[din0_WIDTH-1] ? (din0_WIDTH'(0) - bus.din0) : bus.din0;

  conv_via_tiling_div_step u_step (
    .rem_in  (prem_q),
    .mag_in  (mag_q),
    .divisor (dvs_q),
    .rem_out (prem_nx),
    .mag_out (mag_nx)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.ap_start) state_d = CALC;
      CALC:    if (cnt_q == '0)  state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ap_idle  = (state_q == IDLE);
    bus.ap_ready = (state_q == IDLE) && bus.ap_start;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      din0_q      <= '0;
      mag_q       <= '0;
      prem_q      <= '0;
      dvs_q       <= '0;
      bus.dout    <= '0;
      bus.rem     <= '0;
      bus.dbz     <= 1'b0;
      bus.ap_done <= 1'b0;
    end else begin
      bus.ap_done <= (state_q == FIX);
      case (state_q)
        IDLE: if (bus.ap_start) begin
          neg_q  <= bus.din0[din0_WIDTH-1];
          zero_q <= (bus.din1 == '0);
          din0_q <= bus.din0;
          mag_q  <= abs_din0;
          dvs_q  <= bus.din1;
          prem_q <= '0;
          cnt_q  <= CNT_W'(DIV_ITERS - 1);
        end
        CALC: begin
          prem_q <= prem_nx;
          mag_q  <= mag_nx;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        FIX: begin
          bus.dbz <= zero_q;
          // zero divisor still spent the full CALC window; its quotient is discarded
          if (zero_q) begin
            bus.dout <= neg_q ? SAT_NEG : SAT_POS;
            bus.rem  <= din0_q;
          end else begin
            bus.dout <= neg_q ? (dout_WIDTH'(0) - mag_q)  : mag_q;
            bus.rem  <= neg_q ? (dout_WIDTH'(0) - prem_q) : prem_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_via_tiling_sdiv_32s_31ns_32_seq.sv
// Scoreboard bench: stimulus pushes model results, a negedge monitor checks every ap_done.
module tb_conv_via_tiling_sdiv_32s_31ns_32_seq;
  import conv_via_tiling_div_pkg::*;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  conv_via_tiling_sdiv_32s_31ns_32_seq_if bus();

  conv_via_tiling_sdiv_32s_31ns_32_seq #(
    .ID(1), .din0_WIDTH(32), .din1_WIDTH(31), .dout_WIDTH(32)
  ) u_dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          fails = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  // C semantics straight from 64-bit integer arithmetic
  function automatic exp_t model(input logic [31:0] a, input logic [30:0] b, input int unsigned at);
    exp_t   e;
    longint sa, sd, q, r;
    sa = longint'($signed(a));
    sd = longint'({1'b0, b});
    if (b == 31'd0) begin
      q = (sa < 0) ? -64'sd2147483648 : 64'sd2147483647;
      r = sa;
      e.z = 1'b1;
    end else begin
      q = sa / sd;
      r = sa % sd;
      e.z = 1'b0;
    end
    e.q  = q[31:0];
    e.r  = r[31:0];
    e.at = at;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, req);
    end
  endtask

  always @(negedge ap_clk) begin : mon
    exp_t e;
    if (!ap_rst && bus.ap_done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL spurious_done at cycle %0d: got dout=%h, want no ap_done", cyc, bus.dout);
      end else begin
        e = sb.pop_front();
        chk("dout", bus.dout, e.q);
        chk("rem", bus.rem, e.r);
        chk("dbz", 32'(bus.dbz), 32'(e.z));
        chk("done_cycle", cyc, e.at);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [30:0] b, input bit hold,
                       output int unsigned acc);
    int n;
    n = 0;
    acc = 0;
    @(negedge ap_clk);
    while (bus.ap_idle !== 1'b1 && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    if (bus.ap_idle !== 1'b1) begin
      chk("idle_timeout", 32'(bus.ap_idle), 32'd1);
      return;
    end
    bus.ap_start = 1'b1;
    bus.din0     = a;
    bus.din1     = b;
    #1;
    chk("ap_ready", 32'(bus.ap_ready), 32'd1);
    acc = cyc;
    sb.push_back(model(a, b, cyc + 34));
    @(posedge ap_clk);
    #1;
    if (!hold) bus.ap_start = 1'b0;
    bus.din0 = $urandom();
    bus.din1 = 31'($urandom());
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog at cycle %0d: got no finish, want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc, acc1, acc2, acc3;
    int          busy_bad;
    int          n;
    logic [31:0] a;
    logic [30:0] b;

    bus.ap_start = 1'b0;
    bus.din0     = '0;
    bus.din1     = '0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_dout", bus.dout, 32'd0);
    chk("rst_rem", bus.rem, 32'd0);
    chk("rst_dbz", 32'(bus.dbz), 32'd0);
    chk("rst_done", 32'(bus.ap_done), 32'd0);
    chk("rst_idle", 32'(bus.ap_idle), 32'd1);
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;

    // latency and busy window
    issue(32'd100, 31'd7, 1'b0, acc);
    busy_bad = 0;
    repeat (34) begin
      @(negedge ap_clk);
      if (bus.ap_idle !== 1'b0) busy_bad++;
    end
    chk("idle_busy_window", 32'(busy_bad), 32'd0);
    @(negedge ap_clk);
    chk("idle_after_done", 32'(bus.ap_idle), 32'd1);

    issue(-32'sd100, 31'd7, 1'b0, acc);
    issue(32'h8000_0000, 31'd1, 1'b0, acc);
    issue(32'd5, 31'd0, 1'b0, acc);
    issue(-32'sd5, 31'd0, 1'b0, acc);
    issue(32'd6, 31'd3, 1'b0, acc);
    issue(32'h7FFF_FFFF, 31'h7FFF_FFFF, 1'b0, acc);

    // start pulse mid-CALC must be ignored
    repeat (5) @(negedge ap_clk);
    bus.ap_start = 1'b1;
    bus.din0     = 32'd123;
    bus.din1     = 31'd4;
    #1;
    chk("ready_while_busy", 32'(bus.ap_ready), 32'd0);
    @(posedge ap_clk);
    #1 bus.ap_start = 1'b0;

    // reset mid-operation discards it
    issue(32'd1000, 31'd3, 1'b0, acc);
    repeat (9) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    sb.delete();
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("midrst_dout", bus.dout, 32'd0);
    chk("midrst_rem", bus.rem, 32'd0);
    chk("midrst_dbz", 32'(bus.dbz), 32'd0);
    chk("midrst_done", 32'(bus.ap_done), 32'd0);
    chk("midrst_idle", 32'(bus.ap_idle), 32'd1);
    repeat (30) @(negedge ap_clk);
    issue(32'd9, 31'd3, 1'b0, acc);

    // back-to-back with ap_start held high
    issue(32'd7, 31'd2, 1'b1, acc1);
    issue(-32'sd7, 31'd2, 1'b1, acc2);
    issue(32'd0, 31'd9, 1'b0, acc3);
    chk("hold_gap1", acc2 - acc1, 32'd35);
    chk("hold_gap2", acc3 - acc2, 32'd35);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'($signed(16'($urandom())));
        default: a = $urandom();
      endcase
      case ($urandom_range(0, 7))
        0:       b = 31'd0;
        1, 2, 3: b = 31'($urandom_range(1, 15));
        4:       b = 31'($urandom_range(1, 65535));
        default: b = 31'($urandom());
      endcase
      issue(a, b, 1'b0, acc);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    repeat (5) @(negedge ap_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
